// File: rtl/mux_n_1_scan.sv
// N:1 multiplexer with a registered valid/ready output, manual select and a round-robin scan mode.
// Define MUX_PARITY_EN to add a registered parity output y_par.
module mux_n_1_scan #(
   parameter int unsigned N  = 8,
   parameter int unsigned W  = 1,
   parameter int unsigned SW = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N*W-1:0]  d,
   input  logic [SW-1:0]   s,
   input  logic            mode,
   input  logic            en,
   output logic [W-1:0]    y,
   output logic [SW-1:0]   y_ch,
   output logic            y_valid,
   input  logic            y_ready,
   output logic            scan_done
`ifdef MUX_PARITY_EN
   ,
   output logic            y_par
`endif
);

   localparam logic [SW-1:0] LastCh = SW'(N - 1);

   logic          load;
   logic [SW-1:0] sel;
   logic [W-1:0]  word;
   logic [SW-1:0] ptr_q, ptr_d;
   logic [W-1:0]  y_q, y_d;
   logic [SW-1:0] ch_q, ch_d;
   logic          valid_q, valid_d;
   logic          done_q, done_d;

   always_comb begin
      load = en & (~valid_q | y_ready);
      // Out-of-range manual selects fall back to the highest channel.
      if (mode) begin
         sel = ptr_q;
      end else if (s > LastCh) begin
         sel = LastCh;
      end else begin
         sel = s;
      end
      word = d[sel*W +: W];
   end

   always_comb begin
      ptr_d   = ptr_q;
      y_d     = y_q;
      ch_d    = ch_q;
      valid_d = valid_q & ~y_ready;
      done_d  = 1'b0;
      // Manual mode parks the pointer so the next sweep starts at channel 0.
      if (!mode) begin
         ptr_d = '0;
      end else if (load) begin
         ptr_d = (ptr_q == LastCh) ? '0 : ptr_q + SW'(1);
      end
      if (load) begin
         y_d     = word;
         ch_d    = sel;
         valid_d = 1'b1;
         done_d  = mode & (ptr_q == LastCh);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q   <= '0;
         y_q     <= '0;
         ch_q    <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         ptr_q   <= ptr_d;
         y_q     <= y_d;
         ch_q    <= ch_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   assign y         = y_q;
   assign y_ch      = ch_q;
   assign y_valid   = valid_q;
   assign scan_done = done_q;

`ifdef MUX_PARITY_EN
   logic par_q, par_d;

   always_comb begin
      par_d = load ? ^word : par_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end

   assign y_par = par_q;
`endif

endmodule

// File: tb/tb_mux_n_1_scan.sv
// Scoreboard bench for mux_n_1_scan (N=6, W=4, SW=3): a driver pushes expected samples,
// a negedge monitor pops them when the DUT presents a new sample.
module tb_mux_n_1_scan;

   localparam int N  = 6;
   localparam int W  = 4;
   localparam int SW = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N*W-1:0]  d = '0;
   logic [SW-1:0]   s = '0;
   logic            mode = 1'b0;
   logic            en = 1'b0;
   logic [W-1:0]    y;
   logic [SW-1:0]   y_ch;
   logic            y_valid;
   logic            y_ready = 1'b0;
   logic            scan_done;
`ifdef MUX_PARITY_EN
   logic            y_par;
`endif

   mux_n_1_scan #(.N(N), .W(W), .SW(SW)) dut (
      .clk       (clk),
      .rst       (rst),
      .d         (d),
      .s         (s),
      .mode      (mode),
      .en        (en),
      .y         (y),
      .y_ch      (y_ch),
      .y_valid   (y_valid),
      .y_ready   (y_ready),
      .scan_done (scan_done)
`ifdef MUX_PARITY_EN
      ,
      .y_par     (y_par)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int y;
      int ch;
      int done;
      int par;
   } item_t;

   item_t q[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   // Reference model state.
   bit    mvalid = 0;
   int    mptr   = 0;
   bit    cur_valid = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; the model predicts what the coming edge captures.
   task automatic step(input bit m, input int sv, input bit e, input bit r,
                       input logic [N*W-1:0] dv);
      int    sel;
      bit    load;
      item_t it;
      @(posedge clk);
      #2;
      cur_valid = mvalid;
      mode    = m;
      s       = SW'(sv);
      en      = e;
      y_ready = r;
      d       = dv;
      load = e && (!mvalid || r);
      if (load) begin
         sel     = m ? mptr : ((sv >= N) ? N - 1 : sv);
         it.y    = int'((dv >> (sel * W)) & 24'hF);
         it.ch   = sel;
         it.done = (m && sel == N - 1) ? 1 : 0;
         it.par  = ^it.y[3:0];
         q.push_back(it);
         mvalid = 1;
      end else if (r) begin
         mvalid = 0;
      end
      if (!m) mptr = 0;
      else if (load) mptr = (mptr + 1) % N;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst = 1'b1;
      en  = 1'b0;
      #1;
      chk("rst_y", int'(y), 0);
      chk("rst_ch", int'(y_ch), 0);
      chk("rst_valid", int'(y_valid), 0);
      chk("rst_done", int'(scan_done), 0);
      q.delete();
      mvalid    = 0;
      mptr      = 0;
      cur_valid = 0;
      @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   // Monitor: pop on each newly presented sample, otherwise outputs must hold.
   item_t last;
   bit    prev_valid = 0;
   bit    prev_acc   = 0;

   always @(negedge clk) begin
      item_t it;
      if (rst) begin
         last       = '{0, 0, 0, 0};
         prev_valid = 0;
         prev_acc   = 0;
      end else begin
         chk("valid", int'(y_valid), int'(cur_valid));
         if (y_valid && (!prev_valid || prev_acc)) begin
            if (q.size() == 0) begin
               chk("spurious_sample", 1, 0);
            end else begin
               it = q.pop_front();
               chk("y", int'(y), it.y);
               chk("y_ch", int'(y_ch), it.ch);
               chk("scan_done", int'(scan_done), it.done);
`ifdef MUX_PARITY_EN
               chk("y_par", int'(y_par), it.par);
`endif
               last = it;
            end
         end else begin
            chk("hold_y", int'(y), last.y);
            chk("hold_ch", int'(y_ch), last.ch);
            chk("hold_done", int'(scan_done), 0);
`ifdef MUX_PARITY_EN
            chk("hold_par", int'(y_par), last.par);
`endif
         end
         prev_valid = y_valid;
         prev_acc   = y_valid && y_ready;
      end
   end

   localparam logic [N*W-1:0] Ramp = 24'h543210;
   localparam logic [N*W-1:0] ParD = 24'h3c9b71;

   initial begin
      bit m;
      do_reset();
      // Manual select, then out-of-range selects clamp to channel 5.
      step(0, 5, 1, 1, Ramp);
      step(0, 7, 1, 1, Ramp);
      step(0, 6, 1, 1, Ramp);
      step(0, 2, 1, 1, Ramp);
      // Scan sweep with wrap.
      for (int i = 0; i < 10; i++) step(1, 0, 1, 1, Ramp);
      // Backpressure mid-sweep while d/s change.
      for (int i = 0; i < 3; i++) step(1, i, 1, 0, ~Ramp);
      for (int i = 0; i < 4; i++) step(1, 0, 1, 1, Ramp);
      // Drain: y_valid falls, y holds.
      step(1, 0, 0, 1, Ramp);
      step(1, 0, 0, 1, Ramp);
      chk("drain_valid", int'(y_valid), 0);
      // Mode switch mid-sweep and back.
      for (int i = 0; i < 3; i++) step(1, 0, 1, 1, Ramp);
      step(0, 1, 1, 1, Ramp);
      step(1, 0, 1, 1, Ramp);
      step(1, 0, 1, 1, Ramp);
      // Parity words 4'hb and 4'h9, with a stall on the first.
      step(0, 2, 1, 1, ParD);
      step(0, 3, 1, 0, ParD);
      step(0, 3, 1, 0, ParD);
      step(0, 3, 1, 1, ParD);
      step(0, 0, 0, 1, ParD);
      // Reset mid-sweep with a sample pending, then first scan load is channel 0.
      for (int i = 0; i < 3; i++) step(1, 0, 1, 0, Ramp);
      do_reset();
      for (int i = 0; i < 3; i++) step(1, 0, 1, 1, Ramp);
      // Randomised traffic.
      m = 1;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 15) == 0) m = ~m;
         step(m, int'($urandom_range(0, 7)), $urandom_range(0, 99) < 85,
              $urandom_range(0, 99) < 70, N*W'($urandom));
      end
      for (int i = 0; i < 3; i++) step(m, 0, 0, 1, Ramp);
      @(negedge clk);
      chk("queue_empty", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_n_1_scan.md
Name: mux_n_1_scan

Overview:
- Parametrised N:1 multiplexer with a registered output and a valid/ready output handshake.
- Two modes:
  - Manual mode: the consumer picks the channel with `s`.
  - Scan mode: an internal pointer sweeps round-robin through channels 0..N-1.
- Sits between a bank of N W-bit sources and a single downstream consumer, such as a serial logger or a shared arithmetic unit.

Parameters:
- N, 8, number of input channels (2..256).
- W, 1, data width per channel in bits (>=1).
- SW, 3, select/pointer width in bits. Constraint: 2^SW >= N.

Ports:
- clk  input  1  clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- d  input  N*W  packed channel data; channel k occupies d[k*W +: W].
- s  input  SW  manual channel select; used only when mode=0.
- mode  input  1  0 = manual select, 1 = round-robin scan.
- en  input  1  load request; no new sample is captured while en=0.
- y  output  W  registered selected data.
- y_ch  output  SW  channel index that produced the current y.
- y_valid  output  1  y/y_ch hold a sample not yet accepted.
- y_ready  input  1  consumer accepts the sample when y_valid=1 and y_ready=1.
- scan_done  output  1  one-cycle pulse, registered, marking the end of a scan sweep.

Behaviour:
- Reset (async, rst=1): y=0, y_ch=0, y_valid=0, scan_done=0, internal ptr=0. Outputs hold these values while rst is high.
- Load condition: load = en & (~y_valid | y_ready). A new sample may therefore be captured in the same cycle the old one is accepted, giving full throughput of 1 sample/clk.
- Latency: a sample is captured at the clk edge where load=1. It appears on y/y_ch with y_valid=1 one cycle later.
- Manual (mode=0):
  - On load, sel=s, with y=d[sel], y_ch=sel.
  - If s >= N, then sel=N-1, i.e. the highest channel is the default.
  - ptr is forced to 0 every cycle while mode=0.
- Scan (mode=1):
  - On load, sel=ptr, with y=d[ptr], y_ch=ptr.
  - ptr increments after each load and wraps from N-1 to 0.
  - ptr does not advance without a load.
- scan_done: asserted for exactly one cycle, coincident with y_valid rising for a sample whose y_ch=N-1 captured in scan mode. It is 0 in all other cases, including manual loads of N-1.
- Stall: y_valid=1 with y_ready=0 means y, y_ch and y_valid are held unchanged. d, s and mode changes are ignored until the sample is accepted.
- Drain: y_valid=1, y_ready=1, en=0 means y_valid becomes 0 next cycle; y and y_ch keep their last values.
- Mode change 1->0 mid-sweep: the next load uses s, and ptr restarts at 0 on re-entry to scan.
- y_ready is ignored while y_valid=0.
- Reset asserted mid-sweep: all state clears immediately. The first post-reset scan load is channel 0.

Optional Feature:
- Macro: MUX_PARITY_EN.
- Defined: adds output port y_par (1 bit), registered with y, equal to the XOR-reduction of the captured channel word. It resets to 0 and is held/stalled identically to y.
- Undefined: the y_par port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: N=8, W=4. Assert rst mid-operation with y_valid=1 -> y=0, y_ch=0, y_valid=0, scan_done=0 without waiting for a clk edge.
- Manual select, out-of-range and defaults:
  - Manual select: mode=0, d={4'h7,4'h6,...,4'h0}, s=5, en=1, y_ready=1 -> one cycle later y=4'h5, y_ch=5, y_valid=1.
  - Out-of-range select: N=6, SW=3, s=7 -> y=d[5], y_ch=5.
- Scan sweep: mode=1, en=1, y_ready=1 held for 10 cycles -> y_ch sequence 0,1,...,7,0,1. scan_done pulses only in the cycle y_ch=7.
- Backpressure: scan mode, y_ready=0 for 3 cycles at y_ch=2 -> y/y_ch frozen at channel 2, ptr stays at 3. After y_ready=1, the next y_ch=3 with no channel skipped or repeated.
- Drain and mode switch:
  - Drain: en=0 with y_valid=1, y_ready=1 -> y_valid=0 next cycle and y unchanged.
  - Mode switch: scan stopped at y_ch=4, then mode=0 with s=1 -> y_ch=1. Return to mode=1 -> first y_ch=0.
- Parity (MUX_PARITY_EN defined): W=4, selected word 4'b1011 -> y_par=1; word 4'b1001 -> y_par=0. Stall behaviour matches y.
